mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single external memory port between the pipeline's instruction-fetch side and data (M-stage) side, producing the `inst_mem_ack` and `data_mem_ack` handshakes the hazard unit uses to stall. The data side has priority because an outstanding M-stage access stalls the entire pipeline. A bounded fairness counter guarantees fetch progress under back-to-back data traffic. The block sits between the core datapath and the memory controller.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive contested data grants before one fetch is forced. Range 0..15; 0 means pure data priority.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held high until `inst_mem_ack`.
- inst_addr  in  32  fetch address; stable while `inst_req` is high.
- inst_rdata  out  32  fetched word; valid in the `inst_mem_ack` cycle.
- inst_mem_ack  out  1  one-cycle completion pulse to the fetch side.
- data_req  in  1  data request; held high until `data_mem_ack`.
- data_we  in  1  1 = store, 0 = load.
- data_be  in  4  byte enables for a store.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_rdata  out  32  load data; valid in the `data_mem_ack` cycle.
- data_mem_ack  out  1  one-cycle completion pulse to the data side.
- mem_req  out  1  request to memory; held until `mem_ready`.
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/32/32  latched command fields.
- mem_rdata  in  32  memory read data; sampled when `mem_ready` = 1.
- mem_ready  in  1  memory completion. Ignored when `mem_req` = 0.

## Operation
- States: IDLE, IBUSY, DBUSY, IACK, DACK.
- **IDLE.** Sample the requests:
  - data_req only: go to DBUSY.
  - inst_req only: go to IBUSY.
  - Both high: go to DBUSY, unless starve_cnt == STARVE_LIMIT and STARVE_LIMIT != 0, in which case go to IBUSY.
  - Neither: stay in IDLE.
- **On grant.** Latch the command into the mem_* registers.
  - Instruction grant: mem_we = 0, mem_be = 4'hF.
  - Data grant: mem_we = data_we, mem_be = data_be.
- **IBUSY / DBUSY.** mem_req = 1. When mem_ready = 1, capture mem_rdata into the matching rdata register and go to IACK or DACK respectively.
- **IACK / DACK.** Pulse the matching ack for exactly one cycle, then return to IDLE. Requests are never sampled in an ACK state, because the requester is still holding its old request during that cycle.
- **starve_cnt (4 bits).**
  - Increments on a data grant made while inst_req was also high. Saturates at 15.
  - Clears to 0 on any instruction grant.
  - Unchanged on an uncontested data grant.
- **Withdrawn request.** If a requester drops its request while BUSY, the access still completes and the ack still pulses. A granted store is never cancelled.
- **data_rdata on stores.** data_rdata is updated on stores too, holding whatever mem_rdata shows; its content is don't-care.
- **Output registers.** inst_rdata and data_rdata hold their value until the next completion on the same side.

## Timing
- Reset values:
  - state = IDLE, starve_cnt = 0.
  - mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
  - inst_rdata = 0, data_rdata = 0, inst_mem_ack = 0, data_mem_ack = 0.
- Access latency, with the request sampled in IDLE at cycle 0 and memory wait W ≥ 0 (mem_ready first high in cycle 1+W):
  - mem_req is high in cycles 1..1+W.
  - The ack is high in cycle 2+W.
  - IDLE is re-entered at cycle 3+W.
- Peak throughput is one access per 3 cycles.
- mem_req is deasserted in the cycle after mem_ready. The memory must not see mem_req high in any ACK or IDLE cycle.
- Reset asserted mid-access: next cycle is IDLE with mem_req = 0 and no ack for the abandoned access. Memory must tolerate the dropped request.
- The two acks are never high in the same cycle. Outputs are registered: no combinational path from any input to any output.

## Test plan
- **Single fetch, W = 0:** inst_req = 1, inst_addr = 0x0000_0040 at cycle 0, mem_rdata = 0x2408_0005 -> mem_req high in cycle 1 with mem_addr = 0x40, mem_we = 0; inst_mem_ack high in cycle 2 with inst_rdata = 0x2408_0005.
- **Contested requests:** inst_req and data_req both high (load at 0x100) -> data granted first; data_mem_ack at cycle 2 (W = 0); the fetch is granted at cycle 3 and inst_mem_ack is high at cycle 5.
- **Starvation, STARVE_LIMIT = 4:** inst_req held high while data_req is re-asserted every IDLE -> 4 data grants, then the 5th grant is instruction; starve_cnt returns to 0.
- **Store with wait states:** data_we = 1, data_be = 4'b0011, data_wdata = 0xDEAD_BEEF, mem_ready delayed W = 3 -> mem_req high in cycles 1..4 with stable mem_be = 4'b0011; data_mem_ack only in cycle 5.
- **Reset mid-access:** reset in cycle 2 of a DBUSY access with W = 5 -> mem_req = 0 from cycle 3; no data_mem_ack; a new inst_req is served normally afterwards.
- **Idle memory:** mem_ready pulsed while idle -> no state change, no ack, rdata registers unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between instruction fetch and data access.
// The data side wins contention; a saturating starvation counter periodically forces a fetch through.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_mem_ack,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IBUSY = 3'd1,
        ST_DBUSY = 3'd2,
        ST_IACK  = 3'd3,
        ST_DACK  = 3'd4
    } state_e;

    localparam logic [3:0] LIMIT_C   = 4'(STARVE_LIMIT);
    localparam logic       FAIR_EN_C = (STARVE_LIMIT != 32'd0);

    state_e      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        inst_ack_q, inst_ack_d;
    logic        data_ack_q, data_ack_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        grant_inst_s, grant_data_s, force_fetch_s;

    // A waiting fetch overrides data priority once the limit of contested data grants is reached.
    assign force_fetch_s = FAIR_EN_C && (starve_cnt_q == LIMIT_C);

    // State register plus every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= 4'd0;
            mem_req_q    <= 1'b0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Next-state and grant decision; requests are only looked at in IDLE.
    always_comb begin
        state_d      = state_q;
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_req && !(inst_req && force_fetch_s)) begin
                    state_d      = ST_DBUSY;
                    grant_data_s = 1'b1;
                end else if (inst_req) begin
                    state_d      = ST_IBUSY;
                    grant_inst_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IBUSY: begin
                if (mem_ready) state_d = ST_IACK;
                else           state_d = ST_IBUSY;
            end
            ST_DBUSY: begin
                if (mem_ready) state_d = ST_DACK;
                else           state_d = ST_DBUSY;
            end
            ST_IACK: state_d = ST_IDLE;
            ST_DACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values: handshakes decode the next state, command fields latch on grant.
    always_comb begin
        mem_req_d    = (state_d == ST_IBUSY) || (state_d == ST_DBUSY);
        inst_ack_d   = (state_d == ST_IACK);
        data_ack_d   = (state_d == ST_DACK);
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        starve_cnt_d = starve_cnt_q;
        if (grant_inst_s) begin
            mem_we_d     = 1'b0;
            mem_be_d     = 4'hF;
            mem_addr_d   = inst_addr;
            starve_cnt_d = 4'd0;
        end else if (grant_data_s) begin
            mem_we_d    = data_we;
            mem_be_d    = data_be;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
            if (inst_req && (starve_cnt_q != 4'hF)) starve_cnt_d = starve_cnt_q + 4'd1;
            else                                     starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
        // Stores capture read data too; its content is don't-care for the data side.
        if ((state_q == ST_IBUSY) && mem_ready)      inst_rdata_d = mem_rdata;
        else if ((state_q == ST_DBUSY) && mem_ready) data_rdata_d = mem_rdata;
        else                                         inst_rdata_d = inst_rdata_q;
    end

    assign mem_req      = mem_req_q;
    assign inst_mem_ack = inst_ack_q;
    assign data_mem_ack = data_ack_q;
    assign mem_we       = mem_we_q;
    assign mem_be       = mem_be_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-timing model (grant cycle plus wait states gives every
// output window) checked each cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic [31:0] inst_rdata;
    logic        inst_mem_ack;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = 4'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic [31:0] data_rdata;
    logic        data_mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready;
    logic        resp_ready = 1'b0;
    logic        idle_pulse = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int mem_wait = 0;

    assign mem_ready = resp_ready | idle_pulse;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_mem_ack(inst_mem_ack),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_mem_ack(data_mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: mem_ready rises after mem_wait cycles of mem_req.
    initial begin
        int rcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                resp_ready = (rcnt == mem_wait);
                rcnt++;
            end else begin
                resp_ready = 1'b0;
                rcnt = 0;
            end
        end
    end

    // Behavioural model: cycle k is the interval after the k-th rising edge.
    int cyc = 0;
    int idle_cyc = 0, req_lo = -10, req_hi = -10, ack_cyc = -10;
    bit side_inst = 1'b0, wdata_known = 1'b1;
    logic [3:0]  m_starve = 4'd0;
    logic        e_req = 1'b0, e_we = 1'b0, e_iack = 1'b0, e_dack = 1'b0;
    logic [3:0]  e_be = 4'd0;
    logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_irdata = 32'd0, e_drdata = 32'd0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                idle_cyc = cyc; req_lo = -10; req_hi = -10; ack_cyc = -10;
                m_starve = 4'd0; wdata_known = 1'b1;
                e_we = 1'b0; e_be = 4'd0; e_addr = 32'd0; e_wdata = 32'd0;
                e_irdata = 32'd0; e_drdata = 32'd0;
            end else begin
                if (cyc - 1 == req_hi) begin
                    if (side_inst) e_irdata = mem_rdata;
                    else           e_drdata = mem_rdata;
                end
                if (cyc - 1 == idle_cyc) begin
                    if (inst_req || data_req) begin
                        side_inst = inst_req && (!data_req || (LIMIT != 0 && int'(m_starve) == LIMIT));
                        req_lo = cyc; req_hi = cyc + mem_wait;
                        ack_cyc = cyc + 1 + mem_wait; idle_cyc = cyc + 2 + mem_wait;
                        if (side_inst) begin
                            e_we = 1'b0; e_be = 4'hF; e_addr = inst_addr; wdata_known = 1'b0;
                            m_starve = 4'd0;
                        end else begin
                            e_we = data_we; e_be = data_be; e_addr = data_addr;
                            e_wdata = data_wdata; wdata_known = 1'b1;
                            if (inst_req && m_starve < 4'd15) m_starve = m_starve + 4'd1;
                        end
                    end else begin
                        idle_cyc = cyc;
                    end
                end
            end
            e_req  = (cyc >= req_lo) && (cyc <= req_hi);
            e_iack = (cyc == ack_cyc) && side_inst;
            e_dack = (cyc == ack_cyc) && !side_inst;
        end
    end

    // Compare every cycle against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                check("mem_req", 32'(mem_req), 32'(e_req));
                check("mem_we", 32'(mem_we), 32'(e_we));
                check("mem_be", 32'(mem_be), 32'(e_be));
                check("mem_addr", mem_addr, e_addr);
                if (wdata_known) check("mem_wdata", mem_wdata, e_wdata);
                check("inst_ack", 32'(inst_mem_ack), 32'(e_iack));
                check("data_ack", 32'(data_mem_ack), 32'(e_dack));
                check("inst_rdata", inst_rdata, e_irdata);
                check("data_rdata", data_rdata, e_drdata);
                check("acks_exclusive", 32'(inst_mem_ack & data_mem_ack), 32'd0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ack(input string name, output bit got_inst);
        bit seen = 1'b0;
        got_inst = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (inst_mem_ack || data_mem_ack) begin
                seen = 1'b1;
                got_inst = inst_mem_ack;
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no ack expected ack within 20 cycles", name);
        end
    endtask

    initial begin
        bit gi;
        repeat (3) step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'd0);
        reset = 1'b0;
        step();

        // Single fetch, no wait states.
        inst_req = 1'b1; inst_addr = 32'h0000_0040; mem_rdata = 32'h2408_0005;
        step();
        check("fetch_c1_req", 32'(mem_req), 32'd1);
        check("fetch_c1_addr", mem_addr, 32'h0000_0040);
        check("fetch_c1_we", 32'(mem_we), 32'd0);
        step();
        check("fetch_c2_ack", 32'(inst_mem_ack), 32'd1);
        check("fetch_c2_rdata", inst_rdata, 32'h2408_0005);
        inst_req = 1'b0;
        step();

        // Contested: data load wins, fetch follows.
        inst_req = 1'b1; inst_addr = 32'h0000_0044;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100; mem_rdata = 32'h1111_2222;
        step();
        check("cont_c1_addr", mem_addr, 32'h0000_0100);
        step();
        check("cont_c2_dack", 32'(data_mem_ack), 32'd1);
        check("cont_c2_drdata", data_rdata, 32'h1111_2222);
        data_req = 1'b0; mem_rdata = 32'h3333_4444;
        step();
        step();
        check("cont_c4_addr", mem_addr, 32'h0000_0044);
        step();
        check("cont_c5_iack", 32'(inst_mem_ack), 32'd1);
        check("cont_c5_irdata", inst_rdata, 32'h3333_4444);
        inst_req = 1'b0;
        step();

        // Starvation: fetch held while data re-requests every IDLE.
        inst_req = 1'b1; inst_addr = 32'h0000_0080;
        data_req = 1'b1; data_addr = 32'h0000_0200;
        for (int g = 0; g < 5; g++) begin
            wait_ack("starve_grant", gi);
            check("starve_side", 32'(gi), (g == 4) ? 32'd1 : 32'd0);
            if (g == 3) check("starve_cnt_at_limit", 32'(dut.starve_cnt_q), 32'd4);
            data_addr = data_addr + 32'd4;
        end
        check("starve_cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
        inst_req = 1'b0;
        wait_ack("starve_tail", gi);
        check("starve_tail_side", 32'(gi), 32'd0);
        data_req = 1'b0;
        step();

        // Store with three wait states.
        mem_wait = 3;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
        data_addr = 32'h0000_0300; data_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h5555_AAAA;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("store_req", 32'(mem_req), 32'd1);
            check("store_be", 32'(mem_be), 32'b0011);
            check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("store_no_ack", 32'(data_mem_ack), 32'd0);
        end
        step();
        check("store_ack", 32'(data_mem_ack), 32'd1);
        check("store_req_low", 32'(mem_req), 32'd0);
        data_req = 1'b0; data_we = 1'b0;
        step();

        // Reset in the middle of a slow data access.
        mem_wait = 5;
        data_req = 1'b1; data_addr = 32'h0000_0400;
        step();
        step();
        reset = 1'b1; data_req = 1'b0;
        step();
        reset = 1'b0;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_drdata", data_rdata, 32'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            check("rst_mid_no_dack", 32'(data_mem_ack), 32'd0);
        end
        mem_wait = 0;
        inst_req = 1'b1; inst_addr = 32'h0000_0500; mem_rdata = 32'h0BAD_F00D;
        wait_ack("post_rst_fetch", gi);
        check("post_rst_side", 32'(gi), 32'd1);
        check("post_rst_irdata", inst_rdata, 32'h0BAD_F00D);
        inst_req = 1'b0;
        step();

        // mem_ready pulsed while idle must be ignored.
        mem_rdata = 32'hFFFF_0000; idle_pulse = 1'b1;
        step();
        idle_pulse = 1'b0;
        step();
        step();
        check("idle_irdata", inst_rdata, 32'h0BAD_F00D);
        check("idle_drdata", data_rdata, 32'd0);
        check("idle_req", 32'(mem_req), 32'd0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
